pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/pipe_stage_buf_sat_counter.sv | 24 ++
 rtl/pipe_stage_buf.sv | 112 +++++++++++
 tb/tb_pipe_stage_buf.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared types for the pipeline-stage buffer.
//   word_t        : default datapath word.
//   ready_mode_t  : how in_ready is derived when the buffer is full.
//   depth_ok()    : legal buffer depths (power of two, 2..8).
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      RDY_NOT_FULL        = 1'b0,  // in_ready = !full
      RDY_NOT_FULL_OR_POP = 1'b1   // in_ready = !full || pop
   } ready_mode_t;

   localparam int STALL_W = 16;

   function automatic bit depth_ok(input int d);
      return (d >= 2) && (d <= 8) && ((d & (d - 1)) == 0);
   endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// sat_counter
//   Saturating up-counter; sticks at all-ones.
//   CLK   : clock, rising edge
//   RST   : async active-high reset, clears the count
//   inc   : count one event this cycle
//   value : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [W-1:0] value
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Small FIFO between two pipeline stages with a halt tag. Once an entry
//   tagged halt is accepted, upstream is blocked; when that entry leaves,
//   'halted' latches until reset.
//   CLK, RST              : clock / async active-high reset
//   in_valid/in_ready     : upstream handshake, in_data + in_halt payload
//   flush                 : discard all entries at the next edge
//   out_valid/out_ready   : downstream handshake, out_data + out_halt head
//   count                 : occupancy
//   halted                : sticky, a halt entry has been popped
//   stall_cnt             : saturating count of in_valid && !in_ready cycles
module pipe_stage_buf
   import cpu_types_pkg::*;
#(
   parameter int          WIDTH      = $bits(word_t),
   parameter int          DEPTH      = 2,
   parameter ready_mode_t READY_MODE = RDY_NOT_FULL
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_halt,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_halt,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     halted,
   output logic [STALL_W-1:0]       stall_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (!depth_ok(DEPTH)) begin : g_depth_chk
      $error("pipe_stage_buf: DEPTH must be a power of two in 2..8");
   end

   typedef struct packed {
      logic             halt;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            halt_pending;
   logic            primed;       // storage holds real data somewhere
   logic            full, push, pop, ready_base;
   entry_t          head;

   assign head      = mem[rd_ptr];
   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready && !flush;

   // Mode 1 lets a full buffer accept when the head leaves in the same cycle.
   assign ready_base = (READY_MODE == RDY_NOT_FULL_OR_POP) ? (!full || pop) : !full;
   assign in_ready   = !(halt_pending || halted) && ready_base;
   assign push       = in_valid && in_ready && !flush;

   // Storage is not reset; show zero until something has been written.
   assign out_data = primed ? head.data : '0;
   assign out_halt = out_valid && head.halt;

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= '{halt: in_halt, data: in_data};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         halt_pending <= 1'b0;
         halted       <= 1'b0;
         primed       <= 1'b0;
      end else begin
         if (push) primed <= 1'b1;
         if (pop && head.halt) halted <= 1'b1;
         if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            halt_pending <= 1'b0;
         end else begin
            // pointers wrap naturally since DEPTH is a power of two
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            // in_ready is low while a halt entry is held, so set and clear
            // never coincide
            if (pop && head.halt)  halt_pending <= 1'b0;
            if (push && in_halt)   halt_pending <= 1'b1;
         end
      end
   end

   sat_counter #(.W(STALL_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (in_valid && !in_ready),
      .value (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
//   Three buffers: u0 DEPTH=2 mode 0, u1 DEPTH=2 mode 1, u2 DEPTH=4 mode 1.
//   A queue-based model predicts every output each cycle.
module tb_pipe_stage_buf;
   import cpu_types_pkg::*;

   localparam int N = 3;

   logic              CLK, RST;
   logic [N-1:0]      in_valid, in_halt, flush, out_ready;
   logic [N-1:0]      in_ready, out_valid, out_halt, halted;
   word_t             in_data  [N];
   word_t             out_data [N];
   logic [3:0]        cnt      [N];
   logic [15:0]       stall    [N];

   function automatic int dep(input int i);
      return (i == 2) ? 4 : 2;
   endfunction
   function automatic bit rm(input int i);
      return (i != 0);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int D = (g == 2) ? 4 : 2;
      logic [$clog2(D):0] c;
      pipe_stage_buf #(
         .WIDTH(32), .DEPTH(D),
         .READY_MODE((g == 0) ? RDY_NOT_FULL : RDY_NOT_FULL_OR_POP)
      ) u_dut (
         .CLK(CLK), .RST(RST),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_data(in_data[g]), .in_halt(in_halt[g]), .flush(flush[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]),
         .out_data(out_data[g]), .out_halt(out_halt[g]),
         .count(c), .halted(halted[g]), .stall_cnt(stall[g])
      );
      assign cnt[g] = 4'(c);
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // reference model
   word_t mq [N][$];
   bit    mh [N][$];
   bit    m_halted [N];
   int    m_stall  [N];

   int n_cmp = 0, n_bad = 0, cur = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL u%0d %s: got %0h expected %0h (t=%0t)", cur, tag, act, exp, $time);
      end
   endtask

   task automatic drive(input int i, input bit v, input word_t d, input bit h,
                        input bit f, input bit r);
      in_valid = '0; in_halt = '0; flush = '0; out_ready = '0;
      in_valid[i] = v; in_data[i] = d; in_halt[i] = h; flush[i] = f; out_ready[i] = r;
   endtask

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         mq[i].delete(); mh[i].delete();
         m_halted[i] = 0; m_stall[i] = 0;
      end
   endtask

   // One clock with instance i's inputs already driven. Reports whether the
   // DUT itself showed a pop this cycle and with which data.
   task automatic cycle(input int i, output bit popped, output word_t pdata);
      int n; bit full, pend, mpop, mrdy, mpush;
      cur   = i;
      n     = mq[i].size();
      full  = (n == dep(i));
      pend  = 0;
      for (int k = 0; k < mh[i].size(); k++) pend |= mh[i][k];
      mpop  = (n > 0) && out_ready[i] && !flush[i];
      mrdy  = !(pend || m_halted[i]) && (rm(i) ? (!full || mpop) : !full);
      mpush = in_valid[i] && mrdy && !flush[i];
      #1;
      chk("in_ready",  in_ready[i],  mrdy);
      chk("out_valid", out_valid[i], n > 0);
      chk("count",     cnt[i],       n);
      chk("halted",    halted[i],    m_halted[i]);
      chk("stall_cnt", stall[i],     m_stall[i]);
      if (n > 0) begin
         chk("out_data", out_data[i], mq[i][0]);
         chk("out_halt", out_halt[i], mh[i][0]);
      end else begin
         chk("out_halt", out_halt[i], 0);
      end
      popped = out_valid[i] && out_ready[i] && !flush[i];
      pdata  = out_data[i];
      @(posedge CLK);
      if (in_valid[i] && !mrdy && m_stall[i] < 65535) m_stall[i]++;
      if (flush[i]) begin
         mq[i].delete(); mh[i].delete();
      end else begin
         if (mpop) begin
            if (mh[i][0]) m_halted[i] = 1;
            void'(mq[i].pop_front()); void'(mh[i].pop_front());
         end
         if (mpush) begin
            mq[i].push_back(in_data[i]); mh[i].push_back(in_halt[i]);
         end
      end
      #1;
   endtask

   initial begin
      bit pp; word_t pd; int pops, k, e;
      RST = 1'b1;
      in_valid = '0; in_halt = '0; flush = '0; out_ready = '0;
      for (int i = 0; i < N; i++) in_data[i] = '0;
      reset_model();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         cur = i;
         chk("rst_count", cnt[i], 0);
         chk("rst_out_valid", out_valid[i], 0);
         chk("rst_out_halt", out_halt[i], 0);
         chk("rst_in_ready", in_ready[i], 1);
         chk("rst_out_data", out_data[i], 0);
         chk("rst_stall", stall[i], 0);
         chk("rst_halted", halted[i], 0);
      end

      // fill / drain on u0
      drive(0, 1, 32'hA, 0, 0, 0); cycle(0, pp, pd);
      drive(0, 1, 32'hB, 0, 0, 0); cycle(0, pp, pd);
      drive(0, 1, 32'hC, 0, 0, 0); cycle(0, pp, pd);   // full: refused
      chk("fill_count", cnt[0], 2);
      e = 0;
      for (int c = 0; c < 3; c++) begin
         drive(0, 0, '0, 0, 0, 1); cycle(0, pp, pd);
         if (pp) begin
            chk("drain_order", pd, (e == 0) ? 32'hA : 32'hB);
            e++;
         end
      end
      chk("drain_pops", e, 2);

      // full throughput on u1
      drive(1, 1, $urandom, 0, 0, 0); cycle(1, pp, pd);
      drive(1, 1, $urandom, 0, 0, 0); cycle(1, pp, pd);
      pops = 0;
      for (int c = 0; c < 10; c++) begin
         drive(1, 1, $urandom, 0, 0, 1); cycle(1, pp, pd);
         if (pp) pops++;
      end
      chk("thru_pops", pops, 10);
      chk("thru_count", cnt[1], 2);
      chk("thru_stall", stall[1], 0);

      // flush beats push and pop
      drive(1, 1, 32'hDEAD, 0, 1, 1); cycle(1, pp, pd);
      chk("flush_count", cnt[1], 0);
      chk("flush_valid", out_valid[1], 0);

      // randomized traffic, no halt tags
      for (int i = 0; i < N; i++)
         for (int c = 0; c < 300; c++) begin
            drive(i, ($urandom % 4) != 0, $urandom, 0, ($urandom % 20) == 0,
                  ($urandom % 3) != 0);
            cycle(i, pp, pd);
         end

      // pointer wrap on u2
      drive(2, 0, '0, 0, 1, 0); cycle(2, pp, pd);
      k = 0; e = 0;
      for (int c = 0; c < 60 && (k < 9 || e < 9); c++) begin
         drive(2, k < 9, word_t'(k), 0, 0, ($urandom % 2) == 1);
         cycle(2, pp, pd);
         if (pp) begin chk("wrap_order", pd, e); e++; end
         if (mq[2].size() > 0 && k < 9 && in_data[2] == word_t'(k) &&
             mq[2][mq[2].size()-1] == word_t'(k)) k++;
      end
      chk("wrap_pushed", k, 9);
      chk("wrap_popped", e, 9);

      // halt on u1
      drive(1, 0, '0, 0, 1, 0); cycle(1, pp, pd);
      drive(1, 1, 32'h1, 0, 0, 0); cycle(1, pp, pd);
      drive(1, 1, 32'h2, 1, 0, 0); cycle(1, pp, pd);
      chk("halt_in_ready", in_ready[1], 0);
      for (int c = 0; c < 3; c++) begin
         drive(1, 1, 32'h3, 0, 0, 1); cycle(1, pp, pd);
      end
      chk("halt_halted", halted[1], 1);
      chk("halt_ready_stays", in_ready[1], 0);
      chk("halt_count", cnt[1], 0);

      // random traffic with occasional halt tags on u2
      for (int c = 0; c < 150; c++) begin
         drive(2, ($urandom % 3) != 0, $urandom, ($urandom % 30) == 0,
               ($urandom % 25) == 0, ($urandom % 2) == 1);
         cycle(2, pp, pd);
      end

      // stall saturation on u0
      drive(0, 1, 32'h5, 0, 0, 0); cycle(0, pp, pd);
      drive(0, 1, 32'h6, 0, 0, 0); cycle(0, pp, pd);
      for (int c = 0; c < 70000; c++) begin
         drive(0, 1, 32'h7, 0, 0, 0); cycle(0, pp, pd);
      end
      cur = 0;
      chk("sat_stall", stall[0], 16'hFFFF);
      chk("sat_count", cnt[0], 2);

      // asynchronous reset between edges
      #2 RST = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         cur = i;
         chk("arst_count", cnt[i], 0);
         chk("arst_stall", stall[i], 0);
         chk("arst_halted", halted[i], 0);
         chk("arst_out_valid", out_valid[i], 0);
      end
      reset_model();
      drive(0, 0, '0, 0, 0, 0);
      @(posedge CLK);
      #1 RST = 1'b0;
      for (int i = 0; i < N; i++) begin
         drive(i, 0, '0, 0, 0, 1); cycle(i, pp, pd);
         chk("arst_in_ready", in_ready[i], 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
